booth_seq_multiplier: RTL

Iterative radix-4 Booth multiplier producing the full-precision 2×WIDTH-bit product of two WIDTH-bit operands, one Booth digit per clock. Successor to the combinational 8-bit signed multiplier in the calculator datapath. It adds:
- a parametrised width;
- a per-operation signed/unsigned mode;
- valid/ready handshakes on both sides;
- an untruncated product.

It sits between the operand registers and the result mux of the calculator ALU.

---
 rtl/booth_seq_multiplier.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_multiplier
// Brief    : Iterative radix-4 Booth multiplier, one digit per clock, full
//            2*WIDTH-bit product, signed/unsigned per operation.
//            Optional macro BOOTH_EARLY_EXIT_EN ends CALC once all remaining
//            digits are zero.
// Revision : 1.0 - initial release
// ============================================================================
module booth_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int c_digits = WIDTH / 2 + 1;
  localparam int c_ext_w  = WIDTH + 2;
  localparam int c_acc_w  = 2 * WIDTH + 4;
  localparam int c_cnt_w  = $clog2(c_digits + 1);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_digits - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [c_ext_w-1:0]   r_x_ext;
  logic [c_ext_w:0]     r_y_sh;
  logic [c_acc_w-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_calc_last;
  logic [c_ext_w-1:0]   w_x_ext_in;
  logic [c_ext_w-1:0]   w_y_ext_in;
  logic [c_ext_w:0]     w_y_next;
  logic [2:0]           w_bits;
  logic                 w_neg, w_one, w_two;
  logic [c_acc_w-1:0]   w_x_acc, w_mag, w_pp, w_pp_al, w_acc_next;

  // Two extra bits make unsigned operands look like positive signed ones
  assign w_x_ext_in = {{2{signed_mode & x[WIDTH-1]}}, x};
  assign w_y_ext_in = {{2{signed_mode & y[WIDTH-1]}}, y};

  assign w_y_next = {{2{r_y_sh[c_ext_w]}}, r_y_sh[c_ext_w:2]};
  assign w_bits   = r_y_sh[2:0];
  assign w_neg    = w_bits[2] & ~(w_bits[1] & w_bits[0]);
  assign w_one    = w_bits[1] ^ w_bits[0];
  assign w_two    = (w_bits[2] ^ w_bits[1]) & ~(w_bits[1] ^ w_bits[0]);
  assign w_x_acc  = {{(c_acc_w - c_ext_w){r_x_ext[c_ext_w-1]}}, r_x_ext};

  always_comb begin
    w_mag = '0;
    if (w_one)
      w_mag = w_x_acc;
    else if (w_two)
      w_mag = w_x_acc << 1;
    w_pp = w_neg ? -w_mag : w_mag;
  end

  assign w_pp_al    = w_pp << {r_cnt, 1'b0};
  assign w_acc_next = r_acc + w_pp_al;

`ifdef BOOTH_EARLY_EXIT_EN
  // Uniform remaining bits (overlap included) decode to all-zero digits
  assign w_calc_last = (r_cnt == c_last) || (&w_y_next) || ~(|w_y_next);
`else
  assign w_calc_last = (r_cnt == c_last);
`endif

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_state_next = S_CALC;
      end
      S_CALC: begin
        if (w_calc_last)
          w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready)
          w_state_next = in_valid ? S_CALC : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_ext   <= '0;
      r_y_sh    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_x_ext <= w_x_ext_in;
      r_y_sh  <= {w_y_ext_in, 1'b0};
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_CALC) begin
      r_acc  <= w_acc_next;
      r_y_sh <= w_y_next;
      r_cnt  <= r_cnt + c_cnt_one;
      if (w_calc_last)
        r_product <= w_acc_next[2*WIDTH-1:0];
    end
  end

  assign product = r_product;

endmodule
`default_nettype wire
